yp_uart_rx: RTL and testbench
=============================

# yp_uart_rx

UART receive stage: the line-side consumer of the UART transmitter. It recovers frames from the serial line and presents each received word with parity and framing status. Frame format matches the transmitter: one start bit (0), DATA_WIDTH data bits LSB first, one even-parity bit (XOR of data bits), one stop bit (1). The block oversamples the line at CLKS_PER_BIT clocks per bit, samples at mid-bit, and emits a one-cycle valid pulse per frame to the downstream consumer.

## Interface
- DATA_WIDTH, default 8: data bits per frame (≥1).
- CLKS_PER_BIT, default 16: i_clk cycles per serial bit (≥2). HALF = floor(CLKS_PER_BIT/2).
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_rx_data  in  1  serial line, asynchronous to i_clk, idles high.
- o_rx_valid  out  1  one-cycle pulse: o_rx_data / o_parity_err / o_frame_err updated this cycle.
- o_rx_data  out  DATA_WIDTH  last received word; held until the next o_rx_valid.
- o_parity_err  out  1  parity mismatch on the last frame; held with o_rx_data.
- o_frame_err  out  1  stop bit sampled 0 on the last frame; held with o_rx_data.
- o_busy  out  1  high in every state other than S_IDLE.

## Operation
- Input synchronizer: two flops, i_rx_data → rx_s; both reset to 1. One further flop rx_s_d for edge detect, reset to 1.
- Bit counter cnt, width $clog2(CLKS_PER_BIT), cleared on every state entry; data-bit index counter 0..DATA_WIDTH-1; shift register filled LSB first.
- States:
  - S_IDLE: on rx_s==0 && rx_s_d==1 (falling edge) → S_START. Low level without an edge does not start a frame.
  - S_START: at cnt==HALF-1 sample rx_s; 0 → S_DATA; 1 → S_IDLE (glitch reject, no output).
  - S_DATA: at cnt==CLKS_PER_BIT-1 sample rx_s into shift register bit [index]; after bit DATA_WIDTH-1 → S_PARITY.
  - S_PARITY: at cnt==CLKS_PER_BIT-1 sample parity bit; parity_err = sampled ^ (^data).
  - S_STOP: at cnt==CLKS_PER_BIT-1 sample stop bit; → S_IDLE unconditionally; frame_err = ~sampled.
- Output register: the cycle after the stop sample, o_rx_valid=1 and o_rx_data/o_parity_err/o_frame_err load together. Frames with errors are still delivered.
- After a frame error the line may still be low; no new frame starts until rx_s returns high and falls again.
- No flow control: downstream must accept o_rx_valid every cycle it is asserted; a new frame overwrites held outputs.

## Timing
- Reset (async assert, any state): state S_IDLE, o_rx_valid=0, o_rx_data=0, o_parity_err=0, o_frame_err=0, o_busy=0, sync flops=1. Reset mid-frame discards the partial frame; no valid pulse follows.
- Input falls at cycle T → rx_s low at T+2, edge detected at T+2, S_START at T+3.
- Start sample at T+2+HALF; data bit k (0-based) sampled at T+2+HALF+(k+1)·CLKS_PER_BIT; parity at T+2+HALF+(DATA_WIDTH+1)·CLKS_PER_BIT; stop at T+2+HALF+(DATA_WIDTH+2)·CLKS_PER_BIT.
- o_rx_valid high at T+3+HALF+(DATA_WIDTH+2)·CLKS_PER_BIT; defaults: T+171.
- S_IDLE is re-entered at mid-stop, so a start bit that immediately follows a full stop bit is detected; back-to-back frames produce valid pulses exactly (DATA_WIDTH+3)·CLKS_PER_BIT cycles apart (defaults: 176).
- Low pulse shorter than HALF cycles: rejected at the start sample, o_busy high for HALF cycles then low, no valid.
- o_busy registered with state: high from T+3 through the stop-sample cycle.

## Test plan
- Clean frame (defaults): 0xA5, parity 0, stop 1, input start at T → o_rx_valid one cycle at T+171, o_rx_data=0xA5, o_parity_err=0, o_frame_err=0; outputs hold afterwards.
- Parity error: 0x01 sent with parity bit 0 → valid at T+171, o_rx_data=0x01, o_parity_err=1, o_frame_err=0.
- Framing error: 0x3C, stop bit 0, line held low 40 cycles then high → o_frame_err=1, o_rx_data=0x3C; no second valid until a new falling edge; next clean frame 0x55 clears both error flags.
- Glitch: 3-cycle low pulse on idle line → no o_rx_valid, o_busy returns 0, next frame 0x81 received correctly.
- Back-to-back: 0x12 then 0xEF, no idle gap → two valid pulses 176 cycles apart with correct data, no errors.
- Reset mid-frame: assert i_rstn low during data bit 4 of 0xFF → all outputs 0 immediately; after release, no valid; next frame 0x0F received correctly.

Source files
------------

// File: rtl/yp_uart_rx.sv
// UART receive stage: oversamples the serial line, recovers start/data/even-parity/stop
// frames and presents each word with parity and framing status on a one-cycle valid pulse.
module yp_uart_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_rx_data,
  output logic                  o_rx_valid,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_err_q, par_err_d;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;

  logic                  sync1_q;
  logic                  rx_s_q;
  logic                  rx_prev_q;
  logic                  fall_edge;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  // All reset to the idle-high line level so reset release never looks like a start.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= i_rx_data;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall_edge = ~rx_s_q & rx_prev_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // Every sampling point clears cnt, which is also the entry to the following state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall_edge) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          // A line back high at mid-start was a glitch; drop it silently.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == IDX_LAST) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          par_err_d = rx_s_q ^ (^shift_q);
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        // Leaving at mid-stop lets a start bit right after a full stop bit be seen.
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          valid_d = 1'b1;
          data_d  = shift_q;
          perr_d  = par_err_q;
          ferr_d  = ~rx_s_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_rx_valid   = valid_q;
  assign o_rx_data    = data_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_yp_uart_rx.sv
// Bench for yp_uart_rx: frames are built bit by bit from a frame description, the expected
// word, status and arrival cycle are queued, and a negedge monitor checks every valid pulse.
module tb_yp_uart_rx;

  localparam int DW   = 8;
  localparam int CPB  = 16;
  localparam int LAT  = 3 + CPB / 2 + (DW + 2) * CPB;
  localparam int EW   = 32 + 2 + DW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_line;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [EW-1:0] exp_q[$];

  logic [DW-1:0] hold_data = '0;
  logic          hold_perr = 1'b0;
  logic          hold_ferr = 1'b0;

  yp_uart_rx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_rx_data   (rx_line),
    .o_rx_valid  (rx_valid),
    .o_rx_data   (rx_data),
    .o_parity_err(parity_err),
    .o_frame_err (frame_err),
    .o_busy      (busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_line = b;
    tick(n);
  endtask

  // Called #1 after a clock edge; the start bit begins now, so T is the current cycle.
  task automatic send_frame(input logic [DW-1:0] data, input logic bad_par,
                            input logic stop_val, input int stop_len);
    int   t0;
    logic par;
    t0  = cyc;
    par = (^data) ^ bad_par;
    exp_q.push_back({32'(t0 + LAT), par ^ (^data), ~stop_val, data});
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DW; i++) drive_bit(data[i], CPB);
    drive_bit(par, CPB);
    drive_bit(stop_val, stop_len);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rx_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: data 0x%0h at cycle %0d, nothing expected", rx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({32'(cyc), parity_err, frame_err, rx_data} !== e) begin
          miscompares++;
          $display("FAIL frame: got cyc %0d perr %0b ferr %0b data 0x%0h, expected cyc %0d perr %0b ferr %0b data 0x%0h",
                   cyc, parity_err, frame_err, rx_data, e[EW-1 -: 32], e[DW+1], e[DW], e[DW-1:0]);
        end
        hold_perr = e[DW+1];
        hold_ferr = e[DW];
        hold_data = e[DW-1:0];
      end
    end else begin
      vectors++;
      if ({parity_err, frame_err, rx_data} !== {hold_perr, hold_ferr, hold_data}) begin
        miscompares++;
        $display("FAIL hold: got perr %0b ferr %0b data 0x%0h, expected perr %0b ferr %0b data 0x%0h",
                 parity_err, frame_err, rx_data, hold_perr, hold_ferr, hold_data);
      end
    end
  end

  initial begin
    int t0;
    rx_line = 1'b1;
    rstn    = 1'b0;
    tick(4);
    check("reset_valid", 32'(rx_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_data", 32'(rx_data), 0);
    rstn = 1'b1;
    tick(5);

    // clean frame with busy boundaries
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, CPB);
      begin
        wait_until(t0 + 2);  check("busy_before_start", 32'(busy), 0);
        wait_until(t0 + 3);  check("busy_at_start", 32'(busy), 1);
        wait_until(t0 + LAT - 1); check("busy_at_stop_sample", 32'(busy), 1);
        wait_until(t0 + LAT); check("busy_after_stop", 32'(busy), 0);
      end
    join
    tick(10);

    send_frame(8'h01, 1'b1, 1'b1, CPB);   // parity error
    tick(7);
    send_frame(8'h3C, 1'b0, 1'b0, 40);    // framing error, line stays low
    rx_line = 1'b1;
    tick(30);
    send_frame(8'h55, 1'b0, 1'b1, CPB);
    tick(5);

    // glitch on idle line
    t0 = cyc;
    drive_bit(1'b0, 3);
    rx_line = 1'b1;
    wait_until(t0 + 5);  check("glitch_busy_high", 32'(busy), 1);
    wait_until(t0 + 10); check("glitch_busy_last", 32'(busy), 1);
    wait_until(t0 + 11); check("glitch_busy_low", 32'(busy), 0);
    tick(10);
    send_frame(8'h81, 1'b0, 1'b1, CPB);

    // back-to-back, no idle gap
    send_frame(8'h12, 1'b0, 1'b1, CPB);
    send_frame(8'hEF, 1'b0, 1'b1, CPB);
    tick(10);

    // reset during data bit 4 of 0xFF
    t0 = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
    drive_bit(1'b1, 6);
    check("busy_mid_frame", 32'(busy), 1);
    rstn      = 1'b0;
    hold_data = '0;
    hold_perr = 1'b0;
    hold_ferr = 1'b0;
    #1;
    check("rst_mid_valid", 32'(rx_valid), 0);
    check("rst_mid_data", 32'(rx_data), 0);
    check("rst_mid_perr", 32'(parity_err), 0);
    check("rst_mid_ferr", 32'(frame_err), 0);
    check("rst_mid_busy", 32'(busy), 0);
    tick(3);
    rstn = 1'b1;
    tick(200);
    send_frame(8'h0F, 1'b0, 1'b1, CPB);
    tick(3);

    // randomized frames, gaps, parity and stop errors
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] d;
      logic          bp, bs;
      int            gap;
      d   = DW'($urandom_range(0, (1 << DW) - 1));
      bp  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 7) == 0);
      gap = bs ? $urandom_range(2, 10) : $urandom_range(0, 12);
      send_frame(d, bp, ~bs, bs ? CPB + $urandom_range(0, 20) : CPB);
      drive_bit(1'b1, gap);
    end

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d frames never delivered, expected 0", exp_q.size());
    end
    tick(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
